// File: rtl/yrv_aux_uart_pkg.sv
// Shared types and constants for the auxiliary UART receive path.
package yrv_aux_uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

  localparam int OVERSAMPLE = 16;

  // One sample-counter step per oversample tick, wrapping every bit time.
  typedef logic [$clog2(OVERSAMPLE)-1:0] scnt_t;

  // Half a bit after the start edge: middle of the start bit.
  localparam scnt_t MID_START = scnt_t'(7);
  // A full bit after the previous mid-point: middle of the next bit.
  localparam scnt_t MID_BIT   = scnt_t'(15);

endpackage

// File: rtl/yrv_sync_fifo.sv
// Synchronous FIFO with valid head output; pointers carry an extra wrap bit.
module yrv_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             pop_ok;
  logic             push_ok;

  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign count     = wr_ptr_q - rd_ptr_q;
  assign head_data = mem_q[rd_ptr_q[AW-1:0]];

  // Next pointers and storage; a pop frees the slot a full-FIFO push reuses.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can leave it unassigned and infer a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    pop_ok   = pop && !empty;
    push_ok  = push && (!full || pop_ok);
    if (push_ok) begin
      mem_d[wr_ptr_q[AW-1:0]] = push_data;
      wr_ptr_d                = wr_ptr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      // NOTE: storage is reset too because head_data is visible while empty and must never be X.
      mem_q    <= '{default: '0};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/yrv_aux_uart_rx.sv
// 8N1 receiver for the auxiliary serial pin: 16x oversampling, byte FIFO.
module yrv_aux_uart_rx
  import yrv_aux_uart_pkg::*;
#(
  parameter int DIV_W      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rx_en,
  input  logic [DIV_W-1:0] baud_div,
  input  logic             aux_uart_rx,
  input  logic             rx_ready,
  output logic             rx_valid,
  output logic [7:0]       rx_data,
  output logic             rx_busy,
  output logic             frame_err,
  output logic             overrun
);

  rx_state_t        state_q, state_d;
  logic             rx_meta_q, rx_meta_d;
  logic             rxs_q, rxs_d;
  logic [DIV_W-1:0] tcnt_q, tcnt_d;
  scnt_t            scnt_q, scnt_d;
  logic [2:0]       bcnt_q, bcnt_d;
  logic [7:0]       shreg_q, shreg_d;
  logic             frame_err_q, frame_err_d;
  logic             overrun_q, overrun_d;

  logic             tick_run;
  logic             tick;
  logic [DIV_W-1:0] reload;
  logic             push;
  logic             pop;
  logic             fifo_empty;
  logic             fifo_full;
  // Occupancy is not consumed by the I/O register block yet.
  logic [$clog2(FIFO_DEPTH):0] fifo_count_unused;

  assign rx_busy   = (state_q != IDLE);
  assign rx_valid  = !fifo_empty;
  assign pop       = rx_valid && rx_ready;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

  // Two-flop synchronizer on the asynchronous pin.
  always_comb begin
    rx_meta_d = aux_uart_rx;
    rxs_d     = rx_meta_q;
  end

  // Oversample tick: counts down only while a frame is being received.
  always_comb begin
    reload   = (baud_div == '0) ? '0 : baud_div - DIV_W'(1);
    tick_run = rx_en && (state_q != IDLE);
    tick     = tick_run && (tcnt_q == '0);
    tcnt_d   = (!tick_run || tick) ? reload : tcnt_q - DIV_W'(1);
  end

  // Frame FSM: next state, counters, shift register and push/error strobes.
  always_comb begin
    state_d     = state_q;
    scnt_d      = scnt_q;
    bcnt_d      = bcnt_q;
    shreg_d     = shreg_q;
    push        = 1'b0;
    frame_err_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!rxs_q) begin
          state_d = START;
          scnt_d  = '0;
        end
      end
      START: begin
        if (tick) begin
          if (scnt_q == MID_START) begin
            if (rxs_q) begin
              state_d = IDLE;
            end else begin
              state_d = DATA;
              scnt_d  = '0;
              bcnt_d  = '0;
            end
          end else begin
            scnt_d = scnt_q + 1'b1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          scnt_d = scnt_q + 1'b1;
          if (scnt_q == MID_BIT) begin
            shreg_d = {rxs_q, shreg_q[7:1]};
            bcnt_d  = bcnt_q + 1'b1;
            if (bcnt_q == 3'd7) state_d = STOP;
          end
        end
      end
      STOP: begin
        if (tick) begin
          scnt_d = scnt_q + 1'b1;
          if (scnt_q == MID_BIT) begin
            state_d     = IDLE;
            push        = rxs_q;
            frame_err_d = !rxs_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // Disabling the receiver abandons any partial frame silently.
    if (!rx_en) begin
      state_d     = IDLE;
      push        = 1'b0;
      frame_err_d = 1'b0;
    end
    overrun_d = push && fifo_full && !pop;
  end

  // Receiver state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      rx_meta_q   <= 1'b1;
      rxs_q       <= 1'b1;
      tcnt_q      <= '0;
      scnt_q      <= '0;
      bcnt_q      <= '0;
      shreg_q     <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rx_meta_q   <= rx_meta_d;
      rxs_q       <= rxs_d;
      tcnt_q      <= tcnt_d;
      scnt_q      <= scnt_d;
      bcnt_q      <= bcnt_d;
      shreg_q     <= shreg_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  yrv_sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_rx_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (shreg_q),
    .pop       (pop),
    .head_data (rx_data),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .count     (fifo_count_unused)
  );

endmodule

// File: tb/tb_yrv_aux_uart_rx.sv
// Directed bench for yrv_aux_uart_rx: clean, glitch, framing, overrun, aborts.
module tb_yrv_aux_uart_rx;

  logic        clk = 1'b0;
  logic        reset;
  logic        rx_en;
  logic [15:0] baud_div;
  logic        aux_uart_rx;
  logic        rx_ready;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_busy;
  logic        frame_err;
  logic        overrun;

  yrv_aux_uart_rx #(.DIV_W(16), .FIFO_DEPTH(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .rx_en       (rx_en),
    .baud_div    (baud_div),
    .aux_uart_rx (aux_uart_rx),
    .rx_ready    (rx_ready),
    .rx_valid    (rx_valid),
    .rx_data     (rx_data),
    .rx_busy     (rx_busy),
    .frame_err   (frame_err),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Observation log, sampled on the falling edge.
  logic [7:0] got_q[$];
  int         rise_q[$];
  int         fe_cnt    = 0;
  int         ov_cnt    = 0;
  int         valid_cnt = 0;
  logic       prev_valid = 1'b0;

  always @(negedge clk) begin
    if (rx_valid && rx_ready) got_q.push_back(rx_data);
    if (frame_err) fe_cnt++;
    if (overrun) ov_cnt++;
    if (rx_valid) valid_cnt++;
    if (rx_valid && !prev_valid) rise_q.push_back(cyc);
    prev_valid = rx_valid;
  end

  int checks   = 0;
  int failures = 0;
  int start_cyc = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Drive one 8N1 frame, cpb clocks per bit; line returns high afterwards.
  task automatic send_byte(input logic [7:0] d, input logic stop_bit, input int cpb);
    @(posedge clk); #1;
    start_cyc   = cyc;
    aux_uart_rx = 1'b0;
    for (int i = 0; i < 8; i++) begin
      repeat (cpb) @(posedge clk);
      #1 aux_uart_rx = d[i];
    end
    repeat (cpb) @(posedge clk);
    #1 aux_uart_rx = stop_bit;
    repeat (cpb) @(posedge clk);
    #1 aux_uart_rx = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    @(posedge clk); #1 rx_ready = 1'b1;
    repeat (12) @(posedge clk);
    #1 rx_ready = 1'b0;
  endtask

  function automatic logic [7:0] got_at(input int idx);
    return (idx < got_q.size()) ? got_q[idx] : 8'hxx;
  endfunction

  int gb, fb, ob, vb, rb, lat;

  initial begin
    reset       = 1'b1;
    rx_en       = 1'b1;
    baud_div    = 16'd4;
    aux_uart_rx = 1'b1;
    rx_ready    = 1'b0;
    idle(3);
    reset = 1'b0;

    // Reset state.
    @(negedge clk);
    check("rst_valid", rx_valid, 0);
    check("rst_data", rx_data, 8'h00);
    check("rst_busy", rx_busy, 0);
    check("rst_ferr", frame_err, 0);
    check("rst_ovr", overrun, 0);
    idle(20);

    // Clean byte 0xA5, consumer always ready.
    gb = got_q.size(); fb = fe_cnt; ob = ov_cnt; vb = valid_cnt; rb = rise_q.size();
    rx_ready = 1'b1;
    send_byte(8'hA5, 1'b1, 64);
    idle(100);
    lat = (rise_q.size() > rb) ? rise_q[rise_q.size()-1] - start_cyc : -1;
    check("clean_cnt", got_q.size() - gb, 1);
    check("clean_data", got_at(gb), 8'hA5);
    check("clean_valid_cycles", valid_cnt - vb, 1);
    check("clean_latency", lat, 611);
    check("clean_ferr", fe_cnt - fb, 0);
    check("clean_ovr", ov_cnt - ob, 0);

    // Glitch: 20-clock low pulse.
    gb = got_q.size(); fb = fe_cnt;
    @(posedge clk); #1 aux_uart_rx = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("glitch_busy_start", rx_busy, 1);
    repeat (10) @(posedge clk);
    #1 aux_uart_rx = 1'b1;
    repeat (17) @(posedge clk);
    @(negedge clk);
    check("glitch_busy_end", rx_busy, 0);
    idle(200);
    check("glitch_push", got_q.size() - gb, 0);
    check("glitch_ferr", fe_cnt - fb, 0);

    // Framing error on 0x3C, then a good 0x5A.
    gb = got_q.size(); fb = fe_cnt; vb = valid_cnt;
    send_byte(8'h3C, 1'b0, 64);
    idle(200);
    check("ferr_pulse", fe_cnt - fb, 1);
    check("ferr_valid", valid_cnt - vb, 0);
    send_byte(8'h5A, 1'b1, 64);
    idle(100);
    check("ferr_next_cnt", got_q.size() - gb, 1);
    check("ferr_next_data", got_at(gb), 8'h5A);
    check("ferr_next_noerr", fe_cnt - fb, 1);

    // Overrun under back-pressure.
    rx_ready = 1'b0;
    gb = got_q.size(); ob = ov_cnt;
    for (int b = 1; b <= 5; b++) send_byte(8'(b), 1'b1, 64);
    idle(50);
    check("ovr_pulse", ov_cnt - ob, 1);
    check("ovr_valid", rx_valid, 1);
    check("ovr_head", rx_data, 8'h01);
    drain();
    idle(5);
    check("ovr_pop_cnt", got_q.size() - gb, 4);
    for (int i = 0; i < 4; i++) check($sformatf("ovr_pop%0d", i), got_at(gb + i), 8'(i + 1));
    check("ovr_empty", rx_valid, 0);

    // Full FIFO, pop in exactly the push cycle of byte 5.
    gb = got_q.size(); ob = ov_cnt;
    for (int b = 1; b <= 4; b++) send_byte(8'(b), 1'b1, 64);
    fork
      send_byte(8'h05, 1'b1, 64);
      begin
        @(posedge clk);
        repeat (610) @(posedge clk);
        #1 rx_ready = 1'b1;
        @(posedge clk);
        #1 rx_ready = 1'b0;
      end
    join
    idle(20);
    check("simul_ovr", ov_cnt - ob, 0);
    check("simul_first_pop", got_at(gb), 8'h01);
    drain();
    idle(5);
    check("simul_pop_cnt", got_q.size() - gb, 5);
    for (int i = 1; i < 5; i++) check($sformatf("simul_pop%0d", i), got_at(gb + i), 8'(i + 1));

    // Reset mid-DATA of 0xFF clears FIFO.
    send_byte(8'h11, 1'b1, 64);
    idle(10);
    check("rabort_prefill", rx_data, 8'h11);
    gb = got_q.size(); fb = fe_cnt;
    fork
      send_byte(8'hFF, 1'b1, 64);
      begin
        @(posedge clk);
        repeat (300) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rabort_busy", rx_busy, 0);
        check("rabort_valid", rx_valid, 0);
      end
    join
    idle(100);
    drain();
    check("rabort_push", got_q.size() - gb, 0);
    check("rabort_ferr", fe_cnt - fb, 0);

    // rx_en low mid-DATA of 0xFF keeps FIFO contents.
    send_byte(8'h22, 1'b1, 64);
    idle(10);
    gb = got_q.size(); fb = fe_cnt;
    fork
      send_byte(8'hFF, 1'b1, 64);
      begin
        @(posedge clk);
        repeat (300) @(posedge clk);
        #1 rx_en = 1'b0;
        @(posedge clk);
        #1 rx_en = 1'b1;
        @(negedge clk);
        check("eabort_busy", rx_busy, 0);
      end
    join
    idle(100);
    check("eabort_valid", rx_valid, 1);
    check("eabort_head", rx_data, 8'h22);
    drain();
    check("eabort_cnt", got_q.size() - gb, 1);
    check("eabort_ferr", fe_cnt - fb, 0);

    // baud_div = 0 behaves as 1: 16 clocks per bit.
    baud_div = 16'd0;
    gb = got_q.size();
    rx_ready = 1'b1;
    send_byte(8'h81, 1'b1, 16);
    idle(40);
    check("fast_cnt", got_q.size() - gb, 1);
    check("fast_data", got_at(gb), 8'h81);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
